mips_mc_control: RTL and testbench

//  Multicycle MIPS main control FSM. Sequences the shared datapath (PC, IR, register file,

---
 rtl/mips_mc_pkg.sv | 64 ++++++
 rtl/mips_mc_wdog.sv | 28 ++
 rtl/mips_mc_control.sv | 184 ++++++++++++++++++
 tb/tb_mips_mc_control.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// and the aluOp / aluSrcB / pcSource codes understood by aluControl and the datapath.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXEC_R,
    R_WB,
    BRANCH,
    JUMP,
    ERROR,
    EXEC_I,
    I_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       error;
  } ctl_t;

  // States that wait on the memory ready handshake.
  function automatic logic is_mem_wait(state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mips_mc_wdog.sv
// Memory watchdog: counts consecutive not-ready cycles while busy and raises
// expire when the budget is spent and ready is still low. TIMEOUT_CYCLES=0 disables it.
module mips_mc_wdog #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ready,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Any ready or leaving a wait state restarts the count for the next access.
  always_ff @(posedge clk) begin
    if (rst || !busy || ready) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && busy && !ready &&
                  (cnt == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM with memory-ready handshake and watchdog.
// Optional MIPS_MC_ADDI_EN adds the addi path (EXEC_I -> I_WB); otherwise addi is illegal.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic       o_iorD,
  output logic       o_memRead,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_memToReg,
  output logic       o_regDst,
  output logic       o_regWrite,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_aluOp,
  output logic [1:0] o_pcSource,
  output logic       o_illegal,
  output logic       o_error
);

  state_t state, state_nxt;
  ctl_t   ctl, ctl_q;
  logic   expire;

  mips_mc_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wdog (
    .clk   (i_clk),
    .rst   (i_rst),
    .busy  (is_mem_wait(state)),
    .ready (i_memReady),
    .expire(expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    case (state)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.pc_source = PCSRC_ALU;
        if (i_memReady) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_nxt    = DECODE;
        end else if (expire) begin
          state_nxt = ERROR;
        end
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is dispatched.
        ctl.alu_src_b = SRCB_IMM_SH2;
        ctl.alu_op    = ALUOP_ADD;
        case (i_opcode)
          OP_RTYPE:     state_nxt = EXEC_R;
          OP_LW, OP_SW: state_nxt = MEM_ADDR;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      state_nxt = EXEC_I;
`else
          OP_ADDI: begin
            ctl.illegal = 1'b1;
            state_nxt   = FETCH;
          end
`endif
          default: begin
            ctl.illegal = 1'b1;
            state_nxt   = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
        state_nxt     = (i_opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (i_memReady) begin
          state_nxt = MEM_WB;
        end else if (expire) begin
          state_nxt = ERROR;
        end
      end
      MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        state_nxt      = FETCH;
      end
      MEM_WRITE: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (i_memReady) begin
          state_nxt = FETCH;
        end else if (expire) begin
          state_nxt = ERROR;
        end
      end
      EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REGB;
        ctl.alu_op    = ALUOP_RTYPE;
        state_nxt     = R_WB;
      end
      R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        state_nxt     = FETCH;
      end
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_REGB;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
        state_nxt         = FETCH;
      end
      JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
        state_nxt     = FETCH;
      end
`ifdef MIPS_MC_ADDI_EN
      EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
        state_nxt     = I_WB;
      end
      I_WB: begin
        ctl.reg_write = 1'b1;
        state_nxt     = FETCH;
      end
`endif
      ERROR: begin
        ctl.error = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Reset blanks every output so an aborted instruction cannot leave a partial write.
  assign ctl_q = i_rst ? '0 : ctl;

  assign o_pcWrite     = ctl_q.pc_write;
  assign o_pcWriteCond = ctl_q.pc_write_cond;
  assign o_iorD        = ctl_q.iord;
  assign o_memRead     = ctl_q.mem_read;
  assign o_memWrite    = ctl_q.mem_write;
  assign o_irWrite     = ctl_q.ir_write;
  assign o_memToReg    = ctl_q.mem_to_reg;
  assign o_regDst      = ctl_q.reg_dst;
  assign o_regWrite    = ctl_q.reg_write;
  assign o_aluSrcA     = ctl_q.alu_src_a;
  assign o_aluSrcB     = ctl_q.alu_src_b;
  assign o_aluOp       = ctl_q.alu_op;
  assign o_pcSource    = ctl_q.pc_source;
  assign o_illegal     = ctl_q.illegal;
  assign o_error       = ctl_q.error;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control: a per-instruction phase list model predicts
// the control word every cycle, including ready delays, watchdog expiry and resets.
module tb_mips_mc_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       error;
  } word_t;

  localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
  localparam logic [5:0] BEQ_OP = 6'b000100, J_OP = 6'b000010, ADDI_OP = 6'b001000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opc = 6'd0;
  logic       rdy = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, error;
  logic [1:0] alu_src_b, alu_op, pc_source;
  word_t      got;

  int n_tests = 0;
  int n_fail  = 0;

  bit    q_rdy[$];
  logic [5:0] q_opc[$];
  word_t q_exp[$];
  string q_tag[$];

  mips_mc_control #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_opcode     (opc),
    .i_memReady   (rdy),
    .o_pcWrite    (pc_write),
    .o_pcWriteCond(pc_write_cond),
    .o_iorD       (iord),
    .o_memRead    (mem_read),
    .o_memWrite   (mem_write),
    .o_irWrite    (ir_write),
    .o_memToReg   (mem_to_reg),
    .o_regDst     (reg_dst),
    .o_regWrite   (reg_write),
    .o_aluSrcA    (alu_src_a),
    .o_aluSrcB    (alu_src_b),
    .o_aluOp      (alu_op),
    .o_pcSource   (pc_source),
    .o_illegal    (illegal),
    .o_error      (error)
  );

  assign got = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, error};

  always #5 clk = ~clk;

  task automatic check(string tag, word_t obs, word_t exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(logic [5:0] op);
    bit ok;
    ok = (op == R_OP) || (op == LW_OP) || (op == SW_OP) || (op == BEQ_OP) || (op == J_OP);
`ifdef MIPS_MC_ADDI_EN
    ok = ok || (op == ADDI_OP);
`endif
    return ok;
  endfunction

  task automatic push(bit r, logic [5:0] o, word_t e, string t);
    q_rdy.push_back(r);
    q_opc.push_back(o);
    q_exp.push_back(e);
    q_tag.push_back(t);
  endtask

  // Phase list of one instruction: fd/md are not-ready cycles before the fetch/memory ready.
  task automatic add_instr(logic [5:0] op, int fd, int md);
    word_t e;
    e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
    for (int i = 0; i < fd; i++) push(1'b0, 6'($urandom), e, "fetch_wait");
    e.ir_write = 1; e.pc_write = 1;
    push(1'b1, 6'($urandom), e, "fetch");
    e = '0; e.alu_src_b = 2'b11; e.illegal = !legal(op);
    push(1'($urandom), op, e, "decode");
    if (legal(op)) begin
      case (op)
        R_OP: begin
          e = '0; e.alu_src_a = 1; e.alu_op = 2'b10;
          push(1'($urandom), op, e, "exec_r");
          e = '0; e.reg_write = 1; e.reg_dst = 1;
          push(1'($urandom), op, e, "r_wb");
        end
        LW_OP, SW_OP: begin
          e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
          push(1'($urandom), op, e, "mem_addr");
          e = '0; e.iord = 1;
          if (op == LW_OP) e.mem_read = 1; else e.mem_write = 1;
          for (int i = 0; i < md; i++) push(1'b0, op, e, "mem_wait");
          push(1'b1, op, e, "mem_access");
          if (op == LW_OP) begin
            e = '0; e.reg_write = 1; e.mem_to_reg = 1;
            push(1'($urandom), op, e, "mem_wb");
          end
        end
        BEQ_OP: begin
          e = '0; e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01;
          push(1'($urandom), op, e, "branch");
        end
        J_OP: begin
          e = '0; e.pc_write = 1; e.pc_source = 2'b10;
          push(1'($urandom), op, e, "jump");
        end
        default: begin
          e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
          push(1'($urandom), op, e, "exec_i");
          e = '0; e.reg_write = 1;
          push(1'($urandom), op, e, "i_wb");
        end
      endcase
    end
  endtask

  task automatic play();
    while (q_exp.size() > 0) begin
      @(negedge clk);
      rst = 1'b0;
      rdy = q_rdy.pop_front();
      opc = q_opc.pop_front();
      #2;
      check(q_tag.pop_front(), got, q_exp.pop_front());
    end
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      opc = 6'd0;
      rdy = 1'b1;
      #2;
      check("reset", got, '0);
    end
  endtask

  function automatic int rand_delay();
    return ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(15, 0));
  endfunction

  initial begin
    word_t e;
    logic [5:0] op;
    logic [5:0] ops[6];
    ops = '{R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP};

    do_reset(3);
    add_instr(R_OP, 0, 0);
    add_instr(LW_OP, 0, 3);
    add_instr(SW_OP, 2, 0);
    add_instr(BEQ_OP, 0, 0);
    add_instr(J_OP, 0, 0);
    add_instr(6'b111111, 0, 0);
    add_instr(ADDI_OP, 0, 0);
    add_instr(R_OP, 15, 0);
    add_instr(LW_OP, 14, 15);
    play();

    // Fetch stuck for 16 cycles: ERROR, held regardless of ready, until reset.
    e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
    for (int i = 0; i < 16; i++) push(1'b0, 6'($urandom), e, "wdog_wait");
    e = '0; e.error = 1;
    for (int i = 0; i < 4; i++) push(1'($urandom), 6'($urandom), e, "error");
    play();
    do_reset(2);

    // Reset during a store's memory wait aborts it.
    add_instr(SW_OP, 0, 5);
    while (q_exp.size() > 5) begin
      void'(q_rdy.pop_back()); void'(q_opc.pop_back());
      void'(q_exp.pop_back()); void'(q_tag.pop_back());
    end
    play();
    do_reset(1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(5, 0) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(5, 0)];
      add_instr(op, rand_delay(), rand_delay());
      play();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
